// File: rtl/uart_cmd_parser_if.sv
// Byte stream, register bus and response FIFO signals of the UART command parser.
// The master modport is the parser; the slave modport is its environment.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       framing_error;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] resp_data;
    logic       resp_wr;
    logic       resp_full;
    logic       busy;
    logic       overrun;

    modport master (
        input  rx_data, rx_ready, framing_error, reg_rdata, resp_full,
        output reg_addr, reg_wdata, reg_we, reg_re, resp_data, resp_wr, busy, overrun
    );

    modport slave (
        output rx_data, rx_ready, framing_error, reg_rdata, resp_full,
        input  reg_addr, reg_wdata, reg_we, reg_re, resp_data, resp_wr, busy, overrun
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes ASCII hex "W<aa><dd>" / "R<aa>" lines into register bus accesses and
// queues a short ASCII response ("K", two hex digits, or "E", each plus EOL).
module uart_cmd_parser #(
    parameter logic [7:0] EOL_CHAR = 8'h0D,
    parameter logic [7:0] IGN_CHAR = 8'h0A
) (
    input logic               CLK,
    input logic               rst_n,
    uart_cmd_parser_if.master bus
);

    typedef enum logic [3:0] {
        StIdle, StA1, StA2, StD1, StD2, StEol, StErr, StExec, StCapt, StResp
    } state_e;

    state_e      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [3:0]  nib_q, nib_d;
    logic [7:0]  addr_p_q, addr_p_d;
    logic [7:0]  data_p_q, data_p_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_eol_q, err_eol_d;
    logic [23:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic       busy, byte_in, bad_frame, is_eol, rx_hex;
    logic [3:0] rx_nib;
    logic       reg_we, reg_re, resp_wr;

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign busy      = (state_q == StExec) || (state_q == StCapt) || (state_q == StResp);
    assign byte_in   = bus.rx_ready && !busy && !bus.framing_error;
    assign bad_frame = bus.framing_error && !busy;
    assign is_eol    = (bus.rx_data == EOL_CHAR);

    always_comb begin
        rx_hex = 1'b0;
        rx_nib = 4'h0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            rx_hex = 1'b1;
            rx_nib = bus.rx_data[3:0];
        end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
            rx_hex = 1'b1;
            rx_nib = bus.rx_data[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        nib_d     = nib_q;
        addr_p_d  = addr_p_q;
        data_p_d  = data_p_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_eol_d = err_eol_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        resp_wr   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bad_frame) begin
                    state_d   = StErr;
                    err_eol_d = 1'b0;
                end else if (byte_in) begin
                    if (bus.rx_data == 8'h57 || bus.rx_data == 8'h77) begin
                        op_wr_d = 1'b1;
                        state_d = StA1;
                    end else if (bus.rx_data == 8'h52 || bus.rx_data == 8'h72) begin
                        op_wr_d = 1'b0;
                        state_d = StA1;
                    end else if (!(is_eol || bus.rx_data == IGN_CHAR)) begin
                        state_d   = StErr;
                        err_eol_d = 1'b0;
                    end
                end
            end
            StA1, StA2, StD1, StD2: begin
                if (bad_frame) begin
                    state_d   = StErr;
                    err_eol_d = 1'b0;
                end else if (byte_in) begin
                    if (!rx_hex) begin
                        // A premature EOL already closes the line, so ERR must not wait for another.
                        state_d   = StErr;
                        err_eol_d = is_eol;
                    end else if (state_q == StA1) begin
                        nib_d   = rx_nib;
                        state_d = StA2;
                    end else if (state_q == StA2) begin
                        addr_p_d = {nib_q, rx_nib};
                        state_d  = op_wr_q ? StD1 : StEol;
                    end else if (state_q == StD1) begin
                        nib_d   = rx_nib;
                        state_d = StD2;
                    end else begin
                        data_p_d = {nib_q, rx_nib};
                        state_d  = StEol;
                    end
                end
            end
            StEol: begin
                if (bad_frame) begin
                    state_d   = StErr;
                    err_eol_d = 1'b0;
                end else if (byte_in) begin
                    if (is_eol) begin
                        // Bus-facing registers only change once a whole command is accepted.
                        addr_d = addr_p_q;
                        if (op_wr_q) wdata_d = data_p_q;
                        state_d = StExec;
                    end else begin
                        state_d   = StErr;
                        err_eol_d = 1'b0;
                    end
                end
            end
            StErr: begin
                if (err_eol_q || (byte_in && is_eol)) begin
                    err_eol_d = 1'b0;
                    sr_d      = {8'h00, EOL_CHAR, 8'h45};
                    cnt_d     = 2'd2;
                    state_d   = StResp;
                end
            end
            StExec: begin
                if (op_wr_q) begin
                    reg_we  = 1'b1;
                    sr_d    = {8'h00, EOL_CHAR, 8'h4B};
                    cnt_d   = 2'd2;
                    state_d = StResp;
                end else begin
                    reg_re  = 1'b1;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                sr_d    = {EOL_CHAR, nib2asc(bus.reg_rdata[3:0]), nib2asc(bus.reg_rdata[7:4])};
                cnt_d   = 2'd3;
                state_d = StResp;
            end
            StResp: begin
                if (!bus.resp_full) begin
                    resp_wr = 1'b1;
                    sr_d    = {8'h00, sr_q[23:8]};
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_wr_q   <= 1'b0;
            nib_q     <= 4'h0;
            addr_p_q  <= 8'h00;
            data_p_q  <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            err_eol_q <= 1'b0;
            sr_q      <= 24'h0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            nib_q     <= nib_d;
            addr_p_q  <= addr_p_d;
            data_p_q  <= data_p_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_eol_q <= err_eol_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;
    assign bus.resp_data = sr_q[7:0];
    assign bus.resp_wr   = resp_wr;
    assign bus.busy      = busy;
    assign bus.overrun   = bus.rx_ready && busy;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized line-level bench for uart_cmd_parser: each line's outcome is predicted
// from the command grammar and every bus/response event is checked as it happens.
module tb_uart_cmd_parser;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(
        .EOL_CHAR(8'h0D),
        .IGN_CHAR(8'h0A)
    ) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          we_cyc = -1;
    int          re_cyc = -1;
    int          wr1_cyc = -1;
    int          resp_seen = 0;
    logic        in_reset = 1'b1;
    logic        exp_ovr = 1'b0;
    logic        full_hold = 1'b0;
    logic        no_full = 1'b1;
    logic [7:0]  mem [256];
    logic [7:0]  exp_resp [$];
    logic [15:0] exp_we [$];
    logic [7:0]  exp_re [$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Register file model: read data appears exactly one cycle after reg_re, noise otherwise.
    always @(posedge CLK) bus.reg_rdata <= bus.reg_re ? mem[bus.reg_addr] : 8'($urandom);

    initial begin
        bus.resp_full = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.resp_full = full_hold ? 1'b1 : (no_full ? 1'b0 : ($urandom_range(0, 3) == 0));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!in_reset) begin
                if (bus.resp_wr) begin
                    if (resp_seen == 0) wr1_cyc = cyc;
                    resp_seen++;
                    chk("wr_while_full", 32'(bus.resp_full), 32'd0);
                    n_cmp++;
                    if (exp_resp.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_resp: got %02h required none", bus.resp_data);
                    end else if (bus.resp_data !== exp_resp[0]) begin
                        n_err++;
                        $display("FAIL resp_data: got %02h required %02h", bus.resp_data,
                                 exp_resp[0]);
                        void'(exp_resp.pop_front());
                    end else begin
                        void'(exp_resp.pop_front());
                    end
                end
                if (bus.reg_we) begin
                    we_cyc = cyc;
                    n_cmp++;
                    if (exp_we.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_we: got %02h/%02h required none",
                                 bus.reg_addr, bus.reg_wdata);
                    end else begin
                        if ({bus.reg_addr, bus.reg_wdata} !== exp_we[0]) begin
                            n_err++;
                            $display("FAIL reg_we_addr_data: got %02h%02h required %04h",
                                     bus.reg_addr, bus.reg_wdata, exp_we[0]);
                        end
                        void'(exp_we.pop_front());
                    end
                end
                if (bus.reg_re) begin
                    re_cyc = cyc;
                    n_cmp++;
                    if (exp_re.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_re: got %02h required none", bus.reg_addr);
                    end else begin
                        if (bus.reg_addr !== exp_re[0]) begin
                            n_err++;
                            $display("FAIL reg_re_addr: got %02h required %02h", bus.reg_addr,
                                     exp_re[0]);
                        end
                        void'(exp_re.pop_front());
                    end
                end
                if (bus.overrun || exp_ovr) chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic bit is_hex(input logic [8:0] t);
        if (t[8]) return 1'b0;
        return (t >= 9'h030 && t <= 9'h039) || (t >= 9'h041 && t <= 9'h046) ||
               (t >= 9'h061 && t <= 9'h066);
    endfunction

    function automatic logic [3:0] hv(input logic [8:0] t);
        int v = int'(t);
        if (v <= 57) return 4'(v - 48);
        if (v <= 70) return 4'(v - 55);
        return 4'(v - 87);
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] n);
        string digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    // kind: 0 no response, 1 write, 2 read, 3 error. t is the line without its EOL.
    function automatic void model(input logic [8:0] t[$], output int kind,
                                  output logic [7:0] a, output logic [7:0] d);
        int s = 0;
        int n;
        kind = 3;
        a = 8'h00;
        d = 8'h00;
        while (s < t.size() && t[s] == 9'h00A) s++;
        n = t.size() - s;
        if (n == 0) begin
            kind = 0;
        end else if ((t[s] == 9'h057 || t[s] == 9'h077) && n == 5 && is_hex(t[s+1]) &&
                     is_hex(t[s+2]) && is_hex(t[s+3]) && is_hex(t[s+4])) begin
            kind = 1;
            a = {hv(t[s+1]), hv(t[s+2])};
            d = {hv(t[s+3]), hv(t[s+4])};
        end else if ((t[s] == 9'h052 || t[s] == 9'h072) && n == 3 && is_hex(t[s+1]) &&
                     is_hex(t[s+2])) begin
            kind = 2;
            a = {hv(t[s+1]), hv(t[s+2])};
        end
    endfunction

    task automatic push_expect(input int kind, input logic [7:0] a, input logic [7:0] d);
        case (kind)
            1: begin
                exp_we.push_back({a, d});
                exp_resp.push_back(8'h4B);
                exp_resp.push_back(8'h0D);
            end
            2: begin
                exp_re.push_back(a);
                exp_resp.push_back(asc(mem[a][7:4]));
                exp_resp.push_back(asc(mem[a][3:0]));
                exp_resp.push_back(8'h0D);
            end
            3: begin
                exp_resp.push_back(8'h45);
                exp_resp.push_back(8'h0D);
            end
            default: ;
        endcase
    endtask

    function automatic void gen_line(output logic [8:0] t[$]);
        string hs = "0123456789abcdefABCDEF";
        int r = $urandom_range(0, 9);
        bit wr = ($urandom_range(0, 1) == 1);
        logic [7:0] b;
        int p;
        t = {};
        if ($urandom_range(0, 3) == 0) t.push_back(9'h00A);
        if (wr) t.push_back(($urandom_range(0, 1) == 1) ? 9'h057 : 9'h077);
        else    t.push_back(($urandom_range(0, 1) == 1) ? 9'h052 : 9'h072);
        repeat (wr ? 4 : 2) t.push_back({1'b0, hs[$urandom_range(0, 21)]});
        if (r >= 7) begin
            p = $urandom_range(0, t.size() - 1);
            case ($urandom_range(0, 2))
                0: begin
                    b = 8'($urandom);
                    if (b == 8'h0D) b = 8'h0E;
                    t[p] = ($urandom_range(0, 1) == 1) ? 9'h100 : {1'b0, b};
                end
                1: t.delete(p);
                default: t.push_back({1'b0, hs[$urandom_range(0, 21)]});
            endcase
        end
    endfunction

    function automatic void str_toks(input string s, output logic [8:0] t[$]);
        t = {};
        for (int i = 0; i < s.len(); i++) t.push_back({1'b0, s[i]});
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Token 9'h100 is a framing_error strobe; others are rx_ready bytes.
    task automatic send_tok(input logic [8:0] t, input int gap);
        tick();
        if (t[8]) begin
            bus.framing_error = 1'b1;
        end else begin
            bus.rx_ready = 1'b1;
            bus.rx_data  = t[7:0];
        end
        last_cyc = cyc;
        tick();
        bus.rx_ready      = 1'b0;
        bus.framing_error = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_toks(input logic [8:0] t[$]);
        for (int i = 0; i < t.size(); i++)
            send_tok(t[i], (i == t.size() - 1) ? 0 : $urandom_range(0, 2));
    endtask

    // Entered one cycle after the EOL strobe; inj >= 0 drops a byte at EOL+1+inj.
    task automatic finish_line(input int inj);
        int guard = 0;
        if (inj >= 0) begin
            if (inj == 1) tick();
            bus.rx_ready = 1'b1;
            bus.rx_data  = 8'($urandom);
            exp_ovr      = 1'b1;
            tick();
            bus.rx_ready = 1'b0;
            exp_ovr      = 1'b0;
        end
        repeat (3) tick();
        while (bus.busy && guard < 200) begin
            tick();
            guard++;
        end
        chk("busy_released", 32'(bus.busy), 32'd0);
        tick();
        chk("resp_left", 32'(exp_resp.size()), 32'd0);
        chk("we_left", 32'(exp_we.size()), 32'd0);
        chk("re_left", 32'(exp_re.size()), 32'd0);
    endtask

    task automatic start_line();
        resp_seen = 0;
        wr1_cyc   = -1;
        we_cyc    = -1;
        re_cyc    = -1;
    endtask

    initial begin
        logic [8:0] t[$];
        int kind;
        logic [7:0] a, d;

        bus.rx_ready      = 1'b0;
        bus.framing_error = 1'b0;
        bus.rx_data       = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h0F] = 8'hA7;
        mem[8'h10] = 8'hC3;
        mem[8'h22] = 8'h5E;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        chk("rst_reg_we", 32'(bus.reg_we), 32'd0);
        chk("rst_reg_re", 32'(bus.reg_re), 32'd0);
        chk("rst_resp_wr", 32'(bus.resp_wr), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        tick();

        // Write with literal expectations and latency.
        start_line();
        exp_we.push_back(16'h3A5C);
        exp_resp.push_back(8'h4B);
        exp_resp.push_back(8'h0D);
        str_toks("W3A5C", t);
        t.push_back(9'h00D);
        send_toks(t);
        finish_line(-1);
        chk("we_latency", 32'(we_cyc - last_cyc), 32'd1);
        chk("wr_latency_write", 32'(wr1_cyc - last_cyc), 32'd2);
        chk("hold_addr", 32'(bus.reg_addr), 32'h3A);
        chk("hold_wdata", 32'(bus.reg_wdata), 32'h5C);

        // Read with literal expectations and latency.
        start_line();
        exp_re.push_back(8'h0F);
        exp_resp.push_back(8'h41);
        exp_resp.push_back(8'h37);
        exp_resp.push_back(8'h0D);
        str_toks("r0f", t);
        t.push_back(9'h00D);
        send_toks(t);
        finish_line(-1);
        chk("re_latency", 32'(re_cyc - last_cyc), 32'd1);
        chk("wr_latency_read", 32'(wr1_cyc - last_cyc), 32'd3);
        chk("read_keeps_wdata", 32'(bus.reg_wdata), 32'h5C);

        // Bad digit, premature EOL, bare EOL/LF.
        start_line();
        exp_resp.push_back(8'h45);
        exp_resp.push_back(8'h0D);
        str_toks("W1G", t);
        t.push_back(9'h00D);
        send_toks(t);
        finish_line(-1);
        start_line();
        exp_resp.push_back(8'h45);
        exp_resp.push_back(8'h0D);
        str_toks("R1", t);
        t.push_back(9'h00D);
        send_toks(t);
        finish_line(-1);
        start_line();
        t = '{9'h00D, 9'h00A};
        send_toks(t);
        finish_line(-1);
        chk("no_resp_bare_eol", 32'(resp_seen), 32'd0);

        // Backpressure held across the whole read response.
        start_line();
        full_hold = 1'b1;
        exp_re.push_back(8'h10);
        exp_resp.push_back(8'h43);
        exp_resp.push_back(8'h33);
        exp_resp.push_back(8'h0D);
        str_toks("R10", t);
        t.push_back(9'h00D);
        send_toks(t);
        repeat (8) tick();
        chk("held_no_wr", 32'(resp_seen), 32'd0);
        full_hold = 1'b0;
        finish_line(-1);
        chk("held_bytes", 32'(resp_seen), 32'd3);

        // Framing error mid-address, then overrun during a write response.
        start_line();
        exp_resp.push_back(8'h45);
        exp_resp.push_back(8'h0D);
        t = '{9'h057, 9'h033, 9'h100, 9'h00D};
        send_toks(t);
        finish_line(-1);
        start_line();
        exp_we.push_back(16'h00FF);
        exp_resp.push_back(8'h4B);
        exp_resp.push_back(8'h0D);
        str_toks("W00FF", t);
        t.push_back(9'h00D);
        send_toks(t);
        finish_line(1);

        // Reset in the middle of a read response.
        start_line();
        exp_re.push_back(8'h22);
        exp_resp.push_back(8'h35);
        exp_resp.push_back(8'h45);
        exp_resp.push_back(8'h0D);
        str_toks("R22", t);
        t.push_back(9'h00D);
        send_toks(t);
        repeat (3) tick();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        #1;
        chk("rst_mid_resp_wr", 32'(bus.resp_wr), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_bytes", 32'(resp_seen), 32'd1);
        exp_resp.delete();
        exp_re.delete();
        exp_we.delete();
        tick();
        tick();
        rst_n    = 1'b1;
        in_reset = 1'b0;
        start_line();
        exp_we.push_back(16'h12AB);
        exp_resp.push_back(8'h4B);
        exp_resp.push_back(8'h0D);
        str_toks("w12ab", t);
        t.push_back(9'h00D);
        send_toks(t);
        finish_line(-1);

        // Randomized lines against the grammar model.
        no_full = 1'b0;
        for (int n = 0; n < 150; n++) begin
            start_line();
            gen_line(t);
            model(t, kind, a, d);
            push_expect(kind, a, d);
            t.push_back(9'h00D);
            send_toks(t);
            finish_line(((kind == 1 || kind == 2) && $urandom_range(0, 3) == 0) ?
                        $urandom_range(0, 1) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
